lsu_align: RTL
==============

# lsu_align

Load/store access unit for the riscv32i datapath, placed directly downstream of the ALU decoder. It consumes the decoder's `lh`/`lb`/`lhu`/`lbu` size flags and the ALU-computed address, and runs one memory access per `start` over a req/ack handshake. For stores it generates word-aligned address, byte enables and replicated write data; for loads it extracts, zero-extends or sign-extends the addressed byte or halfword. Misaligned accesses are flagged without touching memory.

## Interface
- `ADDR_W`, 32: address width; `addr` and `mem_addr` use this width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin an access; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `lb`, `lh`, `lbu`, `lhu`  in  1 each  size/extension flags in decoder encoding: lbu implies lb, lhu implies lh; lb=lh=0 is a word access.
- `addr`  in  ADDR_W  byte address from the ALU.
- `wdata`  in  32  store data, right-justified.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  high together with `done` when the access was rejected.
- `rdata`  out  32  aligned, extended load result.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write strobe qualifier.
- `mem_addr`  out  ADDR_W  word address; bits [1:0] are always 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory accepted the request (write) or returned `mem_rdata` (read).
- `mem_rdata`  in  32  read data; valid when `mem_ack` is high.

## Operation
- FSM states: IDLE, REQ, DONE, ERR. All outputs are registered.
- IDLE:
  - On `start`, latch `we`, size flags, `addr` and `wdata`.
  - Misaligned access goes to ERR; otherwise go to REQ.
- Misaligned definition:
  - Halfword (lh=1, lb=0) with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - Byte accesses are never misaligned.
- Size decode: if lb=lh=1, lb wins (byte access). `lbu` and `lhu` only select zero-extension.
- REQ:
  - `mem_req`=1 and `mem_addr`={addr[ADDR_W-1:2],2'b00}.
  - `mem_we`=latched `we`; `mem_be` and `mem_wdata` are held stable.
  - Stay in REQ until `mem_ack`=1. On ack, capture the load result (loads only) and go to DONE.
- `mem_be` encoding:
  - Word: 4'b1111.
  - Half: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
  - Byte: 4'b0001<<addr[1:0].
  - The same encoding applies to loads.
- `mem_wdata`: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extraction:
  - Byte: lane mem_rdata[8*addr[1:0]+:8], sign-extended unless lbu=1.
  - Half: lane mem_rdata[16*addr[1]+:16], sign-extended unless lhu=1.
  - Word: mem_rdata unchanged.
- DONE: `done`=1 for one cycle, then IDLE. `rdata` holds the last load result until the next load completes. Stores leave `rdata` unchanged.
- ERR: `done`=1 and `misaligned`=1 for one cycle, then IDLE. No `mem_req` is issued and `rdata` is unchanged.
- `start` while `busy`=1 is ignored; no queuing.

## Timing
- Reset: state=IDLE. `busy`, `done`, `misaligned`, `mem_req`, `mem_we` = 0. `mem_addr`, `mem_be`, `mem_wdata`, `rdata` = 0.
- Reset mid-access drops `mem_req` asynchronously; no `done` is produced.
- Accepted access:
  - `start` at cycle 0 gives `mem_req`/`busy`=1 from cycle 1.
  - With `mem_ack` at cycle k≥1, `mem_req` is 0 at cycle k+1 and `done`=1 at cycle k+1.
  - Minimum latency is start→done = 2 cycles.
- Misaligned: `start` at cycle 0 gives `done`=`misaligned`=1 at cycle 1; `busy`=1 during that cycle only.
- `mem_ack` outside REQ is ignored.
- `start` in the same cycle as `done`: ignored (state is not IDLE). Earliest restart is the cycle after `done`.
- `rdata` is valid from the `done` cycle onward.

## Test plan
- Load byte, signed: addr=0x1003, mem_rdata=0x80FF_1234, ack on first REQ cycle → mem_addr=0x1000, mem_be=4'b1000, rdata=0xFFFF_FF80, done 2 cycles after start.
- Load halfword, unsigned: lh=lhu=1, addr=0x2002, mem_rdata=0x9ABC_0000, ack delayed 3 cycles → mem_req held 4 cycles, mem_be=4'b1100, rdata=0x0000_9ABC.
- Store byte: we=1, lb=1, addr=0x11, wdata=0x0000_00A5 → mem_we=1, mem_addr=0x10, mem_be=4'b0010, mem_wdata=0xA5A5_A5A5; rdata unchanged.
- Misaligned word: addr=0x6 → done=misaligned=1 at cycle 1, mem_req never asserted.
- Misaligned half: lh=1, addr=0x5 → same rejection as the misaligned word.
- Busy `start` and reset: pulse `start` during REQ → no second access. Drop reset_n during REQ → mem_req=0 immediately, no done, all outputs at reset values.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store access unit: one aligned memory access per start over req/ack,
// with byte-enable/lane-replication for stores and lane extraction/extension for loads.
module lsu_align #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              we,
  input  logic              lb,
  input  logic              lh,
  input  logic              lbu,
  input  logic              lhu,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic        is_byte, is_half, mis;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        byte_q, half_q, uns_q;
  logic [1:0]  off_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // lb takes priority over lh; the u-flags only choose zero-extension
  always_comb begin
    is_byte = lb;
    is_half = lh & ~lb;
    mis     = 1'b0;
    be_c    = 4'b1111;
    wdata_c = wdata;
    if (is_byte) begin
      be_c    = 4'b0001 << addr[1:0];
      wdata_c = {4{wdata[7:0]}};
    end else if (is_half) begin
      mis     = addr[0];
      be_c    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{wdata[15:0]}};
    end else begin
      mis     = (addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = mis ? ERR : REQ;
      REQ:     if (mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    if (byte_q)      ld_val = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
    else if (half_q) ld_val = {{16{ld_half[15] & ~uns_q}}, ld_half};
    else             ld_val = mem_rdata;
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE) || (state_nxt == ERR);
      misaligned <= (state_nxt == ERR);
      mem_req    <= (state_nxt == REQ);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      byte_q    <= 1'b0;
      half_q    <= 1'b0;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      rdata     <= 32'h0;
    end else begin
      if (state == IDLE && start && !mis) begin
        mem_we    <= we;
        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
        byte_q    <= is_byte;
        half_q    <= is_half;
        uns_q     <= is_byte ? lbu : lhu;
        off_q     <= addr[1:0];
      end
      if (state == REQ && mem_ack && !mem_we) rdata <= ld_val;
    end
  end

endmodule
